// File: rtl/iter_shift_unit_pkg.sv
// Shared definitions for the iterative shifter.
// Holds the op encodings, the controller state encodings and the default
// data width. No ports.
// Configuration macro used by the files that import this package: ROTATE_EN.
package shift_pkg;

    localparam int SHIFT_N = 32;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/iter_shift_unit_if.sv
// Controller <-> shifter handshake bundle.
//   start    request, sampled only while the shifter is idle
//   op       00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate only with ROTATE_EN)
//   data_in  operand, captured with start
//   shamt    shift amount 0..N-1, captured with start
//   busy     high while shifting and in the done cycle
//   done     one-cycle pulse, result valid in that cycle
//   result   shift register contents
// master = controller side, slave = shifter side.
interface iter_shift_unit_if #(
    parameter int N = shift_pkg::SHIFT_N
);
    localparam int SHW = $clog2(N);

    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   data_in;
    logic [SHW-1:0] shamt;
    logic           busy;
    logic           done;
    logic [N-1:0]   result;

    modport master (
        output start, op, data_in, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data_in, shamt,
        output busy, done, result
    );

endinterface

// File: rtl/iter_shift_unit_shift1_stage.sv
// Single-bit shift stage, purely combinational.
//   d   in  N  value to shift
//   op  in  2  shift operation (shift_pkg::op_e encoding)
//   q   out N  d shifted by one position
// Every output bit is one mux2x1 choosing its left or right neighbour; only
// the fill bits at the ends depend on the operation.
// ROTATE_EN defined: the MSB fill for OP_ROR is d[0]. Undefined: no rotate
// fill path exists (the top level holds the register for op 11).

// Basic 2:1 mux cell: y = s ? b : a.
module mux2x1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

module shift1_stage
    import shift_pkg::*;
#(
    parameter int N = SHIFT_N
) (
    input  logic [N-1:0] d,
    input  logic [1:0]   op,
    output logic [N-1:0] q
);

    logic left;
    logic msb_fill;

    assign left = (op_e'(op) == OP_SLL);

    always_comb begin
        msb_fill = 1'b0;
        case (op_e'(op))
            OP_SRA:  msb_fill = d[N-1];
`ifdef ROTATE_EN
            OP_ROR:  msb_fill = d[0];
`endif
            default: msb_fill = 1'b0;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic from_left;
        logic from_right;

        if (i == 0) begin : g_lsb
            assign from_left = 1'b0;
        end else begin : g_lmid
            assign from_left = d[i-1];
        end

        if (i == N - 1) begin : g_msb
            assign from_right = msb_fill;
        end else begin : g_rmid
            assign from_right = d[i+1];
        end

        mux2x1 u_mux (
            .a (from_right),
            .b (from_left),
            .s (left),
            .y (q[i])
        );
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA (and ROR with ROTATE_EN) by a runtime
// amount, one bit per clock through a single shift1_stage.
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset; discards any operation
//   bus  slave side of iter_shift_unit_if (start/op/data_in/shamt in,
//        busy/done/result out)
// Timing: start accepted in cycle t with shamt=k gives done in cycle t+k+1,
// busy over t+1..t+k+1. start while busy is ignored.
// ROTATE_EN undefined: op 11 spends shamt cycles but leaves result equal to
// the captured operand.
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int N = SHIFT_N
) (
    input  logic             clk,
    input  logic             rst,
    iter_shift_unit_if.slave bus
);

    localparam int SHW = $clog2(N);

    state_e         state;
    op_e            op_q;
    logic [SHW-1:0] cnt;
    logic [N-1:0]   result_q;
    logic [N-1:0]   shifted;
    logic [N-1:0]   step;
    logic           busy_q;
    logic           done_q;

    shift1_stage #(.N(N)) u_stage (
        .d  (result_q),
        .op (op_q),
        .q  (shifted)
    );

    always_comb begin
        step = shifted;
`ifndef ROTATE_EN
        // Illegal op 11: keep the operand while the cycle count runs down.
        if (op_q == OP_ROR) begin
            step = result_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_SLL;
            cnt      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q     <= op_e'(bus.op);
                        cnt      <= bus.shamt;
                        result_q <= bus.data_in;
                        busy_q   <= 1'b1;
                        if (bus.shamt == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    result_q <= step;
                    cnt      <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: directed scenarios with literal expectations,
// then randomized traffic (including starts while busy and random resets)
// checked every cycle against a timeline model of the handshake and an
// arithmetic model of the shift result.
module tb_iter_shift_unit;
    import shift_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iter_shift_unit_if #(.N(N)) bus ();

    iter_shift_unit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of shifting d by k under op, from plain arithmetic.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int k);
        logic signed [31:0] s;
        s = d;
        case (op)
            2'b00:   return d << k;
            2'b01:   return d >> k;
            2'b10:   return 32'(s >>> k);
`ifdef ROTATE_EN
            default: return (k == 0) ? d : ((d >> k) | (d << (32 - k)));
`else
            default: return d;
`endif
        endcase
    endfunction

    // Timeline model: cycle index of the last acceptance and of its done cycle.
    int          cyc     = 0;
    int          acc_at  = -1;
    int          done_at = -1;
    logic [31:0] pending = '0;
    logic [31:0] held    = '0;
    bit          armed   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            acc_at  = -1;
            done_at = -1;
            pending = '0;
            held    = '0;
            armed   = 1'b1;
        end else if (bus.start && cyc > done_at) begin
            acc_at  = cyc;
            done_at = cyc + int'(bus.shamt) + 1;
            pending = ref_shift(bus.op, bus.data_in, int'(bus.shamt));
        end
        cyc++;
    end

    always @(negedge clk) begin : cmp
        bit eb;
        bit ed;
        if (armed) begin
            eb = (cyc > acc_at) && (cyc <= done_at);
            ed = (cyc == done_at);
            check("busy", 32'(bus.busy), 32'(eb));
            check("done", 32'(bus.done), 32'(ed));
            if (ed) begin
                check("result_at_done", bus.result, pending);
                held = pending;
            end else if (!eb) begin
                check("result_idle", bus.result, held);
            end
        end
    end

    // Present one request for one cycle; returns in the first cycle after acceptance.
    task automatic drive(input logic [1:0] op, input logic [31:0] d, input int k);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.data_in = d;
        bus.shamt   = 5'(k);
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    // Counts cycles (current cycle = 1) until done; bounded.
    task automatic wait_done(input string name, output int lat, output logic [31:0] res);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        res  = '0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                seen = 1'b1;
                res  = bus.result;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    int          lat;
    logic [31:0] res;
    int          pulses;

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.data_in = '0;
        bus.shamt   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Model pins.
        check("pin_sll", ref_shift(2'b00, 32'h0000_00F0, 4), 32'h0000_0F00);
        check("pin_sra", ref_shift(2'b10, 32'h8000_0000, 31), 32'hFFFF_FFFF);
        check("pin_srl", ref_shift(2'b01, 32'h8000_0000, 31), 32'h0000_0001);

        // SLL by 4.
        drive(2'b00, 32'h0000_00F0, 4);
        wait_done("t1", lat, res);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_result", res, 32'h0000_0F00);

        // SRA / SRL by 31, back to back.
        drive(2'b10, 32'h8000_0000, 31);
        wait_done("t2a", lat, res);
        check("t2a_latency", 32'(lat), 32'd32);
        check("t2a_result", res, 32'hFFFF_FFFF);
        drive(2'b01, 32'h8000_0000, 31);
        wait_done("t2b", lat, res);
        check("t2b_result", res, 32'h0000_0001);

        // Zero shift.
        drive(2'b00, 32'hDEAD_BEEF, 0);
        wait_done("t3", lat, res);
        check("t3_latency", 32'(lat), 32'd1);
        check("t3_result", res, 32'hDEAD_BEEF);

        // Start re-asserted mid-operation must be ignored.
        drive(2'b01, 32'h0000_FF00, 8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.data_in = 32'h0000_0001;
        bus.shamt   = 5'd1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        wait_done("t4", lat, res);
        check("t4_latency", 32'(lat), 32'd6);
        check("t4_result", res, 32'h0000_00FF);
        drive(2'b00, 32'h0000_0001, 3);
        wait_done("t4b", lat, res);
        check("t4b_result", res, 32'h0000_0008);

        // Reset in the middle of a long operation.
        drive(2'b01, 32'hFFFF_FFFF, 10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_done", 32'(bus.done), 32'd0);
        check("t5_result", bus.result, 32'h0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("t5_no_done", 32'(pulses), 32'd0);

        // Op 11.
        drive(2'b11, 32'h0000_0001, 1);
        wait_done("t6", lat, res);
        check("t6_latency", 32'(lat), 32'd2);
`ifdef ROTATE_EN
        check("t6_result", res, 32'h8000_0000);
`else
        check("t6_result", res, 32'h0000_0001);
`endif

        // Randomized traffic; the compare process checks every cycle.
        repeat (3000) begin
            @(posedge clk); #1;
            rst         = ($urandom_range(0, 149) == 0);
            bus.start   = ($urandom_range(0, 2) == 0);
            bus.op      = 2'($urandom);
            bus.data_in = $urandom;
            bus.shamt   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
